// File: rtl/shift_seq.sv
// shift_seq: sequential bit-serial shifter (one bit per cycle); rotate enabled by SHIFT_SEQ_ROTATE_EN
module shift_seq #(
    parameter int N = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  din,
    input  logic [SW-1:0] amt,
    input  logic          dir,
    input  logic [1:0]    mode,
    output logic [N-1:0]  dout,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  dout_q, dout_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [1:0]    mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rot, arith;
    logic [N-1:0]  shr, shl;

`ifdef SHIFT_SEQ_ROTATE_EN
    assign rot = mode_q == 2'b10;
`else
    assign rot = 1'b0;
`endif
    assign arith = mode_q == 2'b01;
    assign shr = {arith ? dout_q[N-1] : rot ? dout_q[0] : 1'b0, dout_q[N-1:1]};
    assign shl = {dout_q[N-2:0], rot ? dout_q[N-1] : 1'b0};

    // next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: if (start) begin
                dout_d  = din;
                cnt_d   = amt;
                dir_d   = dir;
                mode_d  = mode;
                state_d = amt == '0 ? DONE : SHIFT;
            end
            SHIFT: begin
                dout_d  = dir_q ? shl : shr;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == SW'(1) ? DONE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == SHIFT;
        done_d = state_d == DONE;
    end

    // state and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dout_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
